// File: rtl/rgb_palette_encoder_if.sv
// Pixel-stream and frame-buffer-write bundle for rgb_palette_encoder.
// The encoder is the slave: it consumes the RGB stream and drives the write side.
interface rgb_palette_encoder_if #(
  parameter int ADDR_W = 19
);
  logic              capture_en;
  logic              s_valid;
  logic              s_ready;
  logic              s_sof;
  logic [7:0]        s_red;
  logic [7:0]        s_green;
  logic [7:0]        s_blue;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              frame_done;

  modport master (
    output capture_en, s_valid, s_sof, s_red, s_green, s_blue,
    input  s_ready, wr_en, wr_addr, wr_data, frame_done
  );

  modport slave (
    input  capture_en, s_valid, s_sof, s_red, s_green, s_blue,
    output s_ready, wr_en, wr_addr, wr_data, frame_done
  );
endinterface

// File: rtl/rgb_palette_encoder.sv
// Maps 24-bit RGB pixels to the nearest of 8 fixed palette codes (Manhattan
// distance, grey code 4'h8 when too far) and writes them into the frame buffer.
module rgb_palette_encoder #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int THRESH = 48
) (
  input  logic                 pixclk,
  input  logic                 rst_n,
  rgb_palette_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_e;

  localparam int                NPIX      = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [9:0]        THRESH_L  = 10'(THRESH);
  localparam logic [23:0]       PALETTE [8] = '{
    24'h000000, 24'hDB203E, 24'h4D191B, 24'hA8B043,
    24'h2B3314, 24'hFFA900, 24'h472812, 24'hFFFFFF
  };

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] diff;
    logic signed [8:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = (diff < 0) ? -diff : diff;
    return 8'(mag);
  endfunction

  function automatic logic [9:0] manhattan(input logic [23:0] px, input logic [23:0] pal);
    return 10'(abs_diff(px[23:16], pal[23:16])) +
           10'(abs_diff(px[15:8],  pal[15:8]))  +
           10'(abs_diff(px[7:0],   pal[7:0]));
  endfunction

  function automatic logic [3:0] grade(input logic [9:0] dmin, input logic [2:0] idx);
    return (dmin > THRESH_L) ? 4'h8 : {1'b0, idx};
  endfunction

  state_e            state_q;
  logic              s_ready_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              accept;
  logic [ADDR_W-1:0] pix_addr;

  logic              vld_p0_q;
  logic [23:0]       pix_p0_q;
  logic [ADDR_W-1:0] addr_p0_q;
  logic              eof_p0_q;

  logic              vld_p1_q;
  logic [9:0]        dist_p1_q [8];
  logic [ADDR_W-1:0] addr_p1_q;
  logic              eof_p1_q;

  logic [9:0]        min_d;
  logic [2:0]        idx_d;
  logic [3:0]        code_d;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3:0]        wr_data_q;
  logic              frame_done_q;

  assign accept   = bus.s_valid & s_ready_q;
  assign pix_addr = bus.s_sof ? '0 : cnt_q;

  // Stage p0: capture FSM; a sof pixel always restarts the frame at address 0
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      cnt_q     <= '0;
      vld_p0_q  <= 1'b0;
    end else begin
      vld_p0_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.capture_en) begin
            state_q   <= WAIT_SOF;
            s_ready_q <= 1'b1;
          end
        end
        WAIT_SOF, ACTIVE: begin
          if (accept && (bus.s_sof || state_q == ACTIVE)) begin
            vld_p0_q <= 1'b1;
            cnt_q    <= pix_addr + ADDR_W'(1);
            if (pix_addr == LAST_ADDR) begin
              state_q   <= bus.capture_en ? WAIT_SOF : IDLE;
              s_ready_q <= bus.capture_en;
            end else begin
              state_q <= ACTIVE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pixclk) begin
    if (accept) begin
      pix_p0_q  <= {bus.s_red, bus.s_green, bus.s_blue};
      addr_p0_q <= pix_addr;
      eof_p0_q  <= (pix_addr == LAST_ADDR);
    end
  end

  // Stage p1: distances to every palette entry
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p0_q;
    end
  end

  always_ff @(posedge pixclk) begin
    for (int i = 0; i < 8; i++) begin
      dist_p1_q[i] <= manhattan(pix_p0_q, PALETTE[i]);
    end
    addr_p1_q <= addr_p0_q;
    eof_p1_q  <= eof_p0_q;
  end

  // Stage p2: strict less-than keeps the lowest index on ties
  always_comb begin
    min_d = dist_p1_q[0];
    idx_d = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (dist_p1_q[i] < min_d) begin
        min_d = dist_p1_q[i];
        idx_d = 3'(i);
      end
    end
    code_d = grade(min_d, idx_d);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= vld_p1_q;
      frame_done_q <= vld_p1_q & eof_p1_q;
      if (vld_p1_q) begin
        wr_addr_q <= addr_p1_q;
        wr_data_q <= code_d;
      end
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_palette_encoder.sv
// Bench for rgb_palette_encoder: two instances (THRESH 48 and 765) on one
// stimulus stream, an FSM/palette model feeding an expected-write queue.
module tb_rgb_palette_encoder;

  localparam int ADDR_W = 19;
  localparam int H_RES  = 4;
  localparam int V_RES  = 2;
  localparam int LAST   = H_RES * V_RES - 1;

  typedef struct {
    int         due;
    int         addr;
    logic [3:0] ca;
    logic [3:0] cb;
    logic       fd;
  } exp_t;

  logic pixclk = 1'b0;
  logic rst_n  = 1'b0;
  bit   fin    = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  exp_t q[$];
  int   cyc     = 0;
  int   m_state = 0;
  bit   m_ready = 1'b0;
  int   m_cnt   = 0;
  int   l_addr  = 0;
  int   l_ca    = 0;
  int   l_cb    = 0;

  int PAL_T [8][3] = '{
    '{0, 0, 0}, '{219, 32, 62}, '{77, 25, 27}, '{168, 176, 67},
    '{43, 51, 20}, '{255, 169, 0}, '{71, 40, 18}, '{255, 255, 255}
  };

  rgb_palette_encoder_if #(.ADDR_W(ADDR_W)) ifa ();
  rgb_palette_encoder_if #(.ADDR_W(ADDR_W)) ifb ();

  assign ifb.capture_en = ifa.capture_en;
  assign ifb.s_valid    = ifa.s_valid;
  assign ifb.s_sof      = ifa.s_sof;
  assign ifb.s_red      = ifa.s_red;
  assign ifb.s_green    = ifa.s_green;
  assign ifb.s_blue     = ifa.s_blue;

  rgb_palette_encoder #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .THRESH(48))
    dut_a (.pixclk(pixclk), .rst_n(rst_n), .bus(ifa));
  rgb_palette_encoder #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .THRESH(765))
    dut_b (.pixclk(pixclk), .rst_n(rst_n), .bus(ifb));

  always #5 pixclk = ~pixclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [3:0] ref_code(input int r, input int g, input int b, input int th);
    int best;
    int bi;
    int d;
    best = 100000;
    bi   = 0;
    for (int i = 0; i < 8; i++) begin
      d = iabs(r - PAL_T[i][0]) + iabs(g - PAL_T[i][1]) + iabs(b - PAL_T[i][2]);
      if (d < best) begin
        best = d;
        bi   = i;
      end
    end
    return (best > th) ? 4'h8 : 4'(bi);
  endfunction

  // Checks what the last rising edge produced, then predicts the next edge.
  always @(negedge pixclk) begin
    exp_t e;
    bit   exp_wr;
    bit   exp_fd;
    int   a;
    cyc++;
    if (!rst_n) begin
      chk("rst_s_ready_a", 32'(ifa.s_ready), 32'd0);
      chk("rst_wr_en_a", 32'(ifa.wr_en), 32'd0);
      chk("rst_wr_addr_a", 32'(ifa.wr_addr), 32'd0);
      chk("rst_wr_data_a", 32'(ifa.wr_data), 32'd0);
      chk("rst_frame_done_a", 32'(ifa.frame_done), 32'd0);
      chk("rst_wr_en_b", 32'(ifb.wr_en), 32'd0);
      chk("rst_wr_data_b", 32'(ifb.wr_data), 32'd0);
      m_state = 0;
      m_ready = 1'b0;
      m_cnt   = 0;
      l_addr  = 0;
      l_ca    = 0;
      l_cb    = 0;
      q.delete();
    end else begin
      exp_wr = (q.size() > 0) && (q[0].due == cyc);
      exp_fd = 1'b0;
      chk("s_ready_a", 32'(ifa.s_ready), 32'(m_ready));
      chk("s_ready_b", 32'(ifb.s_ready), 32'(m_ready));
      chk("wr_en_a", 32'(ifa.wr_en), 32'(exp_wr));
      chk("wr_en_b", 32'(ifb.wr_en), 32'(exp_wr));
      if (exp_wr) begin
        e      = q.pop_front();
        l_addr = e.addr;
        l_ca   = int'(e.ca);
        l_cb   = int'(e.cb);
        exp_fd = e.fd;
      end
      chk("wr_addr_a", 32'(ifa.wr_addr), 32'(l_addr));
      chk("wr_addr_b", 32'(ifb.wr_addr), 32'(l_addr));
      chk("wr_data_a", 32'(ifa.wr_data), 32'(l_ca));
      chk("wr_data_b", 32'(ifb.wr_data), 32'(l_cb));
      chk("frame_done_a", 32'(ifa.frame_done), 32'(exp_fd));
      chk("frame_done_b", 32'(ifb.frame_done), 32'(exp_fd));

      if (m_state == 0) begin
        if (ifa.capture_en) begin
          m_state = 1;
          m_ready = 1'b1;
        end
      end else if (ifa.s_valid && m_ready && (ifa.s_sof || m_state == 2)) begin
        a = ifa.s_sof ? 0 : m_cnt;
        q.push_back('{cyc + 3, a,
                      ref_code(int'(ifa.s_red), int'(ifa.s_green), int'(ifa.s_blue), 48),
                      ref_code(int'(ifa.s_red), int'(ifa.s_green), int'(ifa.s_blue), 765),
                      (a == LAST)});
        m_cnt = a + 1;
        if (a == LAST) begin
          m_state = ifa.capture_en ? 1 : 0;
          m_ready = ifa.capture_en;
        end else begin
          m_state = 2;
        end
      end
    end
    if (fin) begin
      chk("drain", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
    end
  end

  task automatic px(input int r, input int g, input int b, input bit sof);
    ifa.s_valid = 1'b1;
    ifa.s_sof   = sof;
    ifa.s_red   = 8'(r);
    ifa.s_green = 8'(g);
    ifa.s_blue  = 8'(b);
    @(posedge pixclk);
    #1;
  endtask

  task automatic idle(input int n);
    ifa.s_valid = 1'b0;
    ifa.s_sof   = 1'b0;
    repeat (n) begin
      @(posedge pixclk);
      #1;
    end
  endtask

  task automatic rnd_px(input bit sof);
    px(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)), sof);
  endtask

  initial begin
    ifa.capture_en = 1'b0;
    ifa.s_valid    = 1'b0;
    ifa.s_sof      = 1'b0;
    ifa.s_red      = 8'd0;
    ifa.s_green    = 8'd0;
    ifa.s_blue     = 8'd0;
    repeat (3) @(posedge pixclk);
    #1;
    rst_n = 1'b1;
    idle(2);
    ifa.capture_en = 1'b1;
    idle(1);

    // exact match, near match, white, grey fallback, then two equidistant ties
    px(219, 32, 62, 1'b1);
    px(220, 30, 60, 1'b0);
    px(250, 250, 250, 1'b0);
    px(127, 127, 127, 1'b0);
    px(74, 32, 22, 1'b0);
    px(22, 25, 10, 1'b0);
    rnd_px(1'b0);
    rnd_px(1'b0);

    // non-sof pixel while waiting is dropped; next sof restarts at 0
    rnd_px(1'b0);
    idle(1);
    px(255, 169, 0, 1'b1);
    px(43, 51, 20, 1'b0);
    px(71, 40, 18, 1'b1);
    px(168, 176, 67, 1'b0);
    rnd_px(1'b0);
    ifa.capture_en = 1'b0;
    for (int i = 0; i < 5; i++) rnd_px(1'b0);
    px(0, 0, 0, 1'b1);
    idle(4);

    ifa.capture_en = 1'b1;
    idle(1);
    for (int f = 0; f < 3; f++) begin
      rnd_px(1'b1);
      for (int i = 1; i <= LAST; i++) begin
        if ($urandom_range(3) == 0) idle(1);
        rnd_px(1'b0);
      end
    end
    idle(2);

    px(219, 32, 62, 1'b1);
    px(255, 255, 255, 1'b0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    px(77, 25, 27, 1'b1);
    px(10, 10, 10, 1'b0);
    idle(6);

    fin = 1'b1;
    repeat (4) @(posedge pixclk);
    $display("FAIL timeout: summary not reached");
    $fatal(1);
  end

endmodule
